memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Shares the single-port RAM between the instruction-fetch and data-memory requesters of the pipelined core.
//  Each request is latched, issued to RAM and held until RAM acknowledges, then a one-cycle response is returned.
//  Its iwait/dwait outputs feed the hazard logic as ihit = ~iwait and dhit = ~dwait, which drives the stalls.
//  Data access has priority; a streak limit guarantees fetch progress; a watchdog bounds a hung RAM.
// PARAMETERS
//  MAX_DSTREAK  4   consecutive data grants allowed while iREN pending before a fetch is forced
//  TIMEOUT      64  cycles in a grant state without ram_ack before the access is aborted as an error
//  TO_W         7   width of timeout counter; must satisfy 2**TO_W > TIMEOUT
// PORTS
//  CLK        in   1   clock, rising edge
//  RST        in   1   synchronous reset, active high
//  iREN       in   1   instruction read request, held until iwait low
//  iaddr      in   32  instruction word address (word_t)
//  dREN       in   1   data read request, held until dwait low
//  dWEN       in   1   data write request, held until dwait low
//  daddr      in   32  data address (word_t)
//  dstore     in   32  data write value (word_t)
//  ram_ack    in   1   RAM completed current access this cycle
//  ram_load   in   32  RAM read data, valid when ram_ack
//  iwait      out  1   low for exactly one cycle = instruction response
//  dwait      out  1   low for exactly one cycle = data response
//  iload      out  32  fetched instruction, valid while iwait low
//  dload      out  32  loaded data, valid while dwait low and access was a read
//  ramREN     out  1   RAM read strobe
//  ramWEN     out  1   RAM write strobe
//  ramaddr    out  32  RAM address
//  ramstore   out  32  RAM write data
//  mem_err    out  1   sticky: a timeout occurred since reset
// BEHAVIOUR
//  Reset: state IDLE; iwait=dwait=1; iload=dload=ramaddr=ramstore=0; ramREN=ramWEN=0; streak=0; timer=0; mem_err=0.
//  All outputs are registered or decoded from registered state only; there is no input-to-output combinational path.
//  States: IDLE, IGRANT, DGRANT, RESP.
//  IDLE arbitration:
//    (dREN|dWEN) & (~iREN | streak<MAX_DSTREAK) -> DGRANT.
//    Otherwise iREN -> IGRANT; otherwise stay.
//    On grant, latch address, store data and op; timer=0.
//  dREN & dWEN together is treated as a write.
//  Streak:
//    +1 (saturating at MAX_DSTREAK) on a DGRANT taken while iREN high.
//    Cleared on an IGRANT, or on a DGRANT taken while iREN low.
//  GRANT states: ramREN/ramWEN and ramaddr/ramstore are driven from latched values; timer increments each cycle.
//    ram_ack -> capture ram_load into iload/dload -> RESP.
//    No ack and timer==TIMEOUT-1 -> RESP with load=0, mem_err<=1.
//    If ack and timeout terminal coincide, the ack wins (normal completion, no error).
//  RESP: strobes low; the granted side's wait is low for this single cycle; next state IDLE unconditionally.
//    A new arbitration therefore happens no earlier than the cycle after RESP.
//  Latency:
//    Request seen at edge 0 -> strobe high from cycle 1.
//    ack in cycle k -> wait low in cycle k+1.
//    Minimum 3 cycles per access.
//  Withdrawn request mid-grant: the RAM access is not aborted (writes still complete); the response pulse is still issued.
//  Both wait outputs are never low in the same cycle.
//  Reset mid-access: next edge returns to reset values; the in-flight RAM op is abandoned.
//  A write response leaves dload unchanged.
// STRUCTURE
//  cpu_types_pkg gains: word_t (existing); typedef enum logic [1:0] {IDLE,IGRANT,DGRANT,RESP} arb_state_t.
//  Sub-module sat_counter #(W,MAX): sync clear/inc, saturating; instantiated for both streak and timer.
//  Arbitration, latching and the FSM stay in memory_arbiter.
// TESTING
//  iREN only, iaddr=0x40, ram_ack 2 cycles after ramREN, ram_load=0x8C220004
//    -> ramaddr=0x40, iwait low 1 cycle, iload=0x8C220004.
//  iREN & dREN together, daddr=0x100
//    -> DGRANT first; then IGRANT; at most one wait low per cycle.
//  iREN held, dREN re-asserted every response, MAX_DSTREAK=4
//    -> exactly 4 data grants, then an IGRANT; streak returns to 0.
//  dWEN, daddr=0x200, dstore=0xDEADBEEF, ram_ack never
//    -> dwait low at cycle 65, dload unchanged, mem_err=1 until RST.
//  RST asserted 1 cycle into DGRANT
//    -> next cycle IDLE, strobes 0, dwait=1, streak/timer=0.
//  dREN dropped during DGRANT
//    -> ramREN held until ack; dwait still pulses once; FSM returns to IDLE.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package memory_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// CPU-side request/response and RAM-side strobe signals of the memory arbiter.
interface memory_arbiter_if;
  import memory_arbiter_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  ram_ack;
  word_t ram_load;

  logic  iwait;
  logic  dwait;
  word_t iload;
  word_t dload;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  logic  mem_err;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ack, ram_load,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ack, ram_load,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

endinterface

// File: rtl/memory_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module memory_arbiter_sat_counter #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port RAM between instruction fetch and data access.
// Data has priority, bounded by a streak limit; a watchdog aborts a hung RAM access.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned TO_W        = 7
) (
  input  logic             CLK,
  input  logic             RST,
  memory_arbiter_if.slave  bus
);

  localparam int unsigned ST_W = $clog2(MAX_DSTREAK + 1);

  arb_state_t      state_q, state_d;
  word_t           addr_q, addr_d;
  word_t           store_q, store_d;
  word_t           iload_q, iload_d;
  word_t           dload_q, dload_d;
  logic            wr_q, wr_d;
  logic            dside_q, dside_d;
  logic            err_q, err_d;

  logic [ST_W-1:0] streak;
  logic [TO_W-1:0] timer;
  logic            in_grant;
  logic            dreq;
  logic            grant_d;
  logic            grant_i;
  logic            timeout;

  assign in_grant = (state_q == IGRANT) || (state_q == DGRANT);
  assign dreq     = bus.dREN | bus.dWEN;
  assign timeout  = (timer == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    iload_d = iload_q;
    dload_d = dload_q;
    wr_d    = wr_q;
    dside_d = dside_q;
    err_d   = err_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    case (state_q)
      IDLE: begin
        if (dreq && (!bus.iREN || (streak < ST_W'(MAX_DSTREAK)))) begin
          grant_d = 1'b1;
          state_d = DGRANT;
          addr_d  = bus.daddr;
          store_d = bus.dstore;
          wr_d    = bus.dWEN;
          dside_d = 1'b1;
        end else if (bus.iREN) begin
          grant_i = 1'b1;
          state_d = IGRANT;
          addr_d  = bus.iaddr;
          wr_d    = 1'b0;
          dside_d = 1'b0;
        end
      end
      IGRANT, DGRANT: begin
        // An ack in the terminal timeout cycle still counts as a normal completion.
        if (bus.ram_ack) begin
          state_d = RESP;
          if (!dside_q) begin
            iload_d = bus.ram_load;
          end else if (!wr_q) begin
            dload_d = bus.ram_load;
          end
        end else if (timeout) begin
          state_d = RESP;
          err_d   = 1'b1;
          if (!dside_q) begin
            iload_d = '0;
          end else if (!wr_q) begin
            dload_d = '0;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      iload_q <= '0;
      dload_q <= '0;
      wr_q    <= 1'b0;
      dside_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      wr_q    <= wr_d;
      dside_q <= dside_d;
      err_q   <= err_d;
    end
  end

  // Streak counts data grants that bypassed a waiting fetch.
  memory_arbiter_sat_counter #(
    .W   (ST_W),
    .MAX (MAX_DSTREAK)
  ) u_streak (
    .clk (CLK),
    .rst (RST),
    .clr (grant_i | (grant_d & ~bus.iREN)),
    .inc (grant_d & bus.iREN),
    .cnt (streak)
  );

  memory_arbiter_sat_counter #(
    .W   (TO_W),
    .MAX (TIMEOUT)
  ) u_timer (
    .clk (CLK),
    .rst (RST),
    .clr (~in_grant),
    .inc (in_grant),
    .cnt (timer)
  );

  assign bus.ramREN   = in_grant & ~wr_q;
  assign bus.ramWEN   = in_grant & wr_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.iwait    = ~((state_q == RESP) & ~dside_q);
  assign bus.dwait    = ~((state_q == RESP) & dside_q);
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.mem_err  = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: transaction-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int MAXS = 4;
  localparam int TMO  = 64;

  logic CLK = 1'b0;
  logic RST;

  memory_arbiter_if bus();

  memory_arbiter #(
    .MAX_DSTREAK (MAXS),
    .TIMEOUT     (TMO),
    .TO_W        (7)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one access record (in flight, or in its response cycle).
  bit    m_busy, m_resp, m_dside, m_wr, m_err;
  word_t m_addr, m_store, m_iload, m_dload;
  int    m_age, m_streak;

  always @(posedge CLK) begin
    if (RST) begin
      m_busy = 0; m_resp = 0; m_dside = 0; m_wr = 0; m_err = 0;
      m_addr = '0; m_store = '0; m_iload = '0; m_dload = '0;
      m_age = 0; m_streak = 0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_busy) begin
      if (bus.ram_ack || m_age == TMO - 1) begin
        if (!m_wr) begin
          if (m_dside) m_dload = bus.ram_ack ? bus.ram_load : 32'h0;
          else         m_iload = bus.ram_ack ? bus.ram_load : 32'h0;
        end
        if (!bus.ram_ack) m_err = 1;
        m_busy = 0;
        m_resp = 1;
      end else begin
        m_age++;
      end
    end else if ((bus.dREN || bus.dWEN) && (!bus.iREN || m_streak < MAXS)) begin
      m_busy = 1; m_dside = 1; m_wr = bus.dWEN; m_age = 0;
      m_addr = bus.daddr; m_store = bus.dstore;
      m_streak = bus.iREN ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
    end else if (bus.iREN) begin
      m_busy = 1; m_dside = 0; m_wr = 0; m_age = 0;
      m_addr = bus.iaddr;
      m_streak = 0;
    end
  end

  bit chk_on = 0;

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("ramREN",  bus.ramREN,  m_busy && !(m_dside && m_wr));
      chk("ramWEN",  bus.ramWEN,  m_busy && m_dside && m_wr);
      chk("iwait",   bus.iwait,   !(m_resp && !m_dside));
      chk("dwait",   bus.dwait,   !(m_resp && m_dside));
      chk("ramaddr", bus.ramaddr, m_addr);
      chk("iload",   bus.iload,   m_iload);
      chk("dload",   bus.dload,   m_dload);
      chk("mem_err", bus.mem_err, m_err);
      chk("one_wait_low", {31'b0, ~bus.iwait & ~bus.dwait}, 32'h0);
      if (m_busy && m_dside && m_wr) chk("ramstore", bus.ramstore, m_store);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = '0; bus.dstore = '0; bus.ram_ack = 0; bus.ram_load = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1;
    tick();
    RST = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  int cyc;
  int wcnt;
  int tgt;
  bit side_d;

  initial begin
    clear_inputs();
    RST = 1;
    repeat (3) tick();
    chk_on = 1;
    chk("rst_iwait",   bus.iwait,   1);
    chk("rst_dwait",   bus.dwait,   1);
    chk("rst_ramREN",  bus.ramREN,  0);
    chk("rst_ramaddr", bus.ramaddr, 0);
    chk("rst_mem_err", bus.mem_err, 0);
    RST = 0;
    tick();

    // Single fetch, ack two cycles after the strobe rises.
    bus.iREN = 1; bus.iaddr = 32'h40;
    tick();
    chk("f_ramREN",  bus.ramREN,  1);
    chk("f_ramaddr", bus.ramaddr, 32'h40);
    tick(); tick();
    bus.ram_ack = 1; bus.ram_load = 32'h8C220004;
    tick();
    chk("f_iwait", bus.iwait, 0);
    chk("f_iload", bus.iload, 32'h8C220004);
    bus.iREN = 0; bus.ram_ack = 0;
    tick();
    chk("f_iwait_after", bus.iwait, 1);

    // Simultaneous requests: data first, then fetch.
    do_reset();
    bus.iREN = 1; bus.iaddr = 32'h80; bus.dREN = 1; bus.daddr = 32'h100;
    tick();
    chk("p_first_addr", bus.ramaddr, 32'h100);
    bus.ram_ack = 1; bus.ram_load = 32'hAAAA5555;
    tick();
    chk("p_dwait", bus.dwait, 0);
    chk("p_iwait", bus.iwait, 1);
    chk("p_dload", bus.dload, 32'hAAAA5555);
    bus.dREN = 0; bus.ram_ack = 0;
    tick(); tick();
    chk("p_second_addr", bus.ramaddr, 32'h80);
    bus.ram_ack = 1; bus.ram_load = 32'h11112222;
    tick();
    chk("p_iwait2", bus.iwait, 0);
    chk("p_iload",  bus.iload, 32'h11112222);
    bus.iREN = 0; bus.ram_ack = 0;
    tick();

    // Streak limit: four data grants, forced fetch, then data again.
    do_reset();
    bus.iREN = 1; bus.iaddr = 32'h300; bus.dREN = 1; bus.daddr = 32'h400;
    tick();
    for (int k = 0; k < 6; k++) begin
      bus.ram_ack = 1; bus.ram_load = 32'(k);
      tick();
      side_d = !bus.dwait;
      chk($sformatf("streak_grant%0d", k), {31'b0, side_d}, (k == 4) ? 32'h0 : 32'h1);
      bus.ram_ack = 0;
      tick(); tick();
    end

    // Watchdog on a write that is never acknowledged; dload must survive it.
    do_reset();
    bus.dREN = 1; bus.daddr = 32'h10;
    tick();
    bus.ram_ack = 1; bus.ram_load = 32'h12345678;
    tick();
    bus.dREN = 0; bus.ram_ack = 0;
    tick();
    bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF;
    tick();
    cyc = 1;
    chk("w_ramWEN",   bus.ramWEN,   1);
    chk("w_ramstore", bus.ramstore, 32'hDEADBEEF);
    chk("w_err_pre",  bus.mem_err,  0);
    while (bus.dwait && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("w_timeout_cycle", cyc, 65);
    chk("w_dload_kept", bus.dload, 32'h12345678);
    chk("w_err_set", bus.mem_err, 1);
    bus.dWEN = 0;
    repeat (5) tick();
    chk("w_err_sticky", bus.mem_err, 1);
    do_reset();
    chk("w_err_clear", bus.mem_err, 0);

    // Reset one cycle into a data grant.
    bus.dREN = 1; bus.daddr = 32'h500;
    tick();
    chk("r_ramREN_pre", bus.ramREN, 1);
    RST = 1;
    tick();
    RST = 0; bus.dREN = 0;
    chk("r_ramREN",  bus.ramREN,  0);
    chk("r_dwait",   bus.dwait,   1);
    chk("r_ramaddr", bus.ramaddr, 0);

    // Data request withdrawn during its grant.
    tick();
    bus.dREN = 1; bus.daddr = 32'h600;
    tick();
    bus.dREN = 0;
    tick();
    chk("x_ramREN_held", bus.ramREN, 1);
    tick();
    bus.ram_ack = 1; bus.ram_load = 32'h0BADF00D;
    tick();
    chk("x_dwait", bus.dwait, 0);
    bus.ram_ack = 0;
    tick();
    chk("x_dwait_after", bus.dwait, 1);
    tick();
    chk("x_idle_ramREN", bus.ramREN, 0);

    // Randomized traffic with occasional hung RAM and stray resets.
    do_reset();
    wcnt = 0;
    tgt  = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!bus.iwait) begin
        bus.iREN = 1'($urandom_range(0, 1)); bus.iaddr = $urandom;
      end else if (!bus.iREN) begin
        if ($urandom_range(0, 2) == 0) begin bus.iREN = 1; bus.iaddr = $urandom; end
      end else if ($urandom_range(0, 59) == 0) begin
        bus.iREN = 0;
      end
      if (!bus.dwait || (!bus.dREN && !bus.dWEN)) begin
        if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0, 3:    begin bus.dREN = 1; bus.dWEN = 0; end
            1:       begin bus.dREN = 0; bus.dWEN = 1; end
            default: begin bus.dREN = 1; bus.dWEN = 1; end
          endcase
          bus.daddr = $urandom; bus.dstore = $urandom;
        end else begin
          bus.dREN = 0; bus.dWEN = 0;
        end
      end else if ($urandom_range(0, 59) == 0) begin
        bus.dREN = 0; bus.dWEN = 0;
      end
      if (bus.ramREN || bus.ramWEN) begin
        bus.ram_ack = (wcnt >= tgt);
        bus.ram_load = $urandom;
        wcnt++;
      end else begin
        bus.ram_ack = ($urandom_range(0, 7) == 0);
        wcnt = 0;
        tgt = ($urandom_range(0, 24) == 0) ? 80 : int'($urandom_range(0, 4));
      end
      RST = ($urandom_range(0, 299) == 0);
      tick();
    end
    RST = 0;
    clear_inputs();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
